constraint_sample_driver: RTL and testbench

- Sequential wrapper around the generated constraint-check stage (inputs var_0..var_4, single output x).
- Upstream side: produces pseudo-random candidate vectors from a 64-bit LFSR and drives them to the checker.
- Downstream side: takes the checker's x result, keeps accepted candidates in a small FIFO, and presents them on a valid/ready stream.
- Keeps try/accept counters and stops when a target count is reached or a try budget without an accept runs out.

---
 rtl/constraint_sample_driver.sv | 244 ++++++++++++++++++++++++
 tb/tb_constraint_sample_driver.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/constraint_sample_driver.sv
// Constraint sample driver: LFSR candidate source, accept FIFO, run FSM.
// Optional SAMPLE_DEDUP_EN rejects a repeat of the last pushed sample.
module constraint_sample_driver #(
   parameter logic [63:0] SEED       = 64'h1,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned MAX_TRIES  = 65535
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] target,
   output logic [12:0] cand_var_0,
   output logic [12:0] cand_var_1,
   output logic [13:0] cand_var_2,
   output logic [13:0] cand_var_3,
   output logic [7:0]  cand_var_4,
   input  logic        chk_x,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [61:0] out_data,
   output logic [31:0] tries_cnt,
   output logic [31:0] accept_cnt,
   output logic        busy,
   output logic        done,
   output logic        timeout
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam logic [63:0] SEED_EFF =
      (SEED == 64'h0) ? 64'h1 : SEED;
   localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;
   localparam logic [31:0] MAX_REJ = 32'(MAX_TRIES);
   localparam logic [31:0] SAT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_STALL,
      S_DONE
   } state_e;

   state_e      state_q, state_d;
   logic [63:0] lfsr_q, lfsr_d;
   logic [31:0] tries_q, tries_d;
   logic [31:0] accept_q, accept_d;
   logic [31:0] rej_q, rej_d;
   logic [15:0] target_q, target_d;
   logic        timeout_q, timeout_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [PW:0] wr_ptr_q, wr_ptr_d;
   logic [PW:0] rd_ptr_q, rd_ptr_d;
   logic [61:0] mem_q [FIFO_DEPTH];

   logic [61:0] cand;
   logic [63:0] lfsr_nx;
   logic [31:0] tries_inc;
   logic [31:0] accept_inc;
   logic [31:0] rej_inc;
   logic        full;
   logic        empty;
   logic        pop;
   logic        push;
   logic        space;
   logic        hit;
   logic        go;

`ifdef SAMPLE_DEDUP_EN
   logic [61:0] last_q, last_d;
`endif

   assign cand       = lfsr_q[61:0];
   assign cand_var_0 = lfsr_q[12:0];
   assign cand_var_1 = lfsr_q[25:13];
   assign cand_var_2 = lfsr_q[39:26];
   assign cand_var_3 = lfsr_q[53:40];
   assign cand_var_4 = lfsr_q[61:54];

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                  (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign out_valid = !empty;
   assign out_data  = mem_q[rd_ptr_q[PW-1:0]];
   assign pop   = out_valid & out_ready;
   assign space = !full | pop;

   assign tries_cnt  = tries_q;
   assign accept_cnt = accept_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign timeout    = timeout_q;

   assign lfsr_nx = (lfsr_q >> 1) ^ ({64{lfsr_q[0]}} & TAPS);
   assign tries_inc  = (tries_q == SAT) ? SAT : tries_q + 32'd1;
   assign accept_inc = (accept_q == SAT) ? SAT : accept_q + 32'd1;
   assign rej_inc    = (rej_q == SAT) ? SAT : rej_q + 32'd1;

`ifdef SAMPLE_DEDUP_EN
   assign hit = chk_x && (cand != last_q);
`else
   assign hit = chk_x;
`endif

   // Next-state logic for the run FSM, counters and FIFO pointers
   always_comb begin
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      tries_d   = tries_q;
      accept_d  = accept_q;
      rej_d     = rej_q;
      target_d  = target_q;
      timeout_d = timeout_q;
      push      = 1'b0;
      go        = 1'b0;
`ifdef SAMPLE_DEDUP_EN
      last_d    = last_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            go = start;
         end
         S_RUN: begin
            if (abort) begin
               state_d   = S_DONE;
               timeout_d = 1'b0;
            end else begin
               tries_d = tries_inc;
               if (hit) begin
                  if (space) begin
                     push     = 1'b1;
                     lfsr_d   = lfsr_nx;
                     rej_d    = 32'd0;
                     accept_d = accept_inc;
                     if (accept_inc >= {16'h0, target_q})
                        state_d = S_DONE;
                  end else begin
                     state_d = S_STALL;
                  end
               end else begin
                  lfsr_d = lfsr_nx;
                  rej_d  = rej_inc;
                  if (rej_inc >= MAX_REJ) begin
                     state_d   = S_DONE;
                     timeout_d = 1'b1;
                  end
               end
            end
         end
         S_STALL: begin
            if (abort) begin
               state_d   = S_DONE;
               timeout_d = 1'b0;
            end else if (space) begin
               push     = 1'b1;
               lfsr_d   = lfsr_nx;
               rej_d    = 32'd0;
               accept_d = accept_inc;
               if (accept_inc >= {16'h0, target_q})
                  state_d = S_DONE;
               else
                  state_d = S_RUN;
            end
         end
         S_DONE: begin
            if (abort)
               timeout_d = 1'b0;
            else
               go = start;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (go) begin
         target_d  = target;
         tries_d   = 32'd0;
         accept_d  = 32'd0;
         rej_d     = 32'd0;
         timeout_d = 1'b0;
         state_d   = (target == 16'd0) ? S_DONE : S_RUN;
      end
`ifdef SAMPLE_DEDUP_EN
      if (go)
         last_d = '1;
      else if (push)
         last_d = cand;
`endif
      busy_d   = (state_d == S_RUN) || (state_d == S_STALL);
      done_d   = (state_d == S_DONE);
      wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop};
   end

   // Control and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         lfsr_q    <= SEED_EFF;
         tries_q   <= 32'd0;
         accept_q  <= 32'd0;
         rej_q     <= 32'd0;
         target_q  <= 16'd0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         tries_q   <= tries_d;
         accept_q  <= accept_d;
         rej_q     <= rej_d;
         target_q  <= target_d;
         timeout_q <= timeout_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   // Accepted-sample storage, written at the tail on push
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q[PW-1:0]] <= cand;
      end
   end

`ifdef SAMPLE_DEDUP_EN
   // Most recently pushed sample for repeat rejection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_q <= '1;
      else
         last_q <= last_d;
   end
`endif

endmodule

// File: tb/tb_constraint_sample_driver.sv
// Scoreboard bench for constraint_sample_driver.
// Bench-side LFSR model predicts every pushed sample.
module tb_constraint_sample_driver;

   localparam int MT = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] target = 16'd0;
   logic        chk_drv = 1'b0;
   logic        dd_mode = 1'b0;
   logic [61:0] dd_last = '1;
   logic        out_ready = 1'b0;
   logic        chk_x;
   logic [12:0] cand_var_0;
   logic [12:0] cand_var_1;
   logic [13:0] cand_var_2;
   logic [13:0] cand_var_3;
   logic [7:0]  cand_var_4;
   logic        out_valid;
   logic [61:0] out_data;
   logic [31:0] tries_cnt;
   logic [31:0] accept_cnt;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [61:0] cand_pack;

   logic [61:0] exp_q [$];
   logic [63:0] m_lfsr;
   int total = 0;
   int bad = 0;
   logic saw;

   assign cand_pack = {cand_var_4, cand_var_3, cand_var_2,
                       cand_var_1, cand_var_0};
   assign chk_x = dd_mode ? (cand_pack == dd_last) : chk_drv;

   constraint_sample_driver #(
      .SEED(64'h1),
      .FIFO_DEPTH(4),
      .MAX_TRIES(MT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .abort(abort),
      .target(target),
      .cand_var_0(cand_var_0),
      .cand_var_1(cand_var_1),
      .cand_var_2(cand_var_2),
      .cand_var_3(cand_var_3),
      .cand_var_4(cand_var_4),
      .chk_x(chk_x),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .tries_cnt(tries_cnt),
      .accept_cnt(accept_cnt),
      .busy(busy),
      .done(done),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] step(input logic [63:0] v);
      return (v >> 1) ^ ({64{v[0]}} & 64'hD800_0000_0000_0000);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string n, input logic [63:0] a,
                      input logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, a, e);
      end
   endtask

   task automatic exp_push();
      exp_q.push_back(m_lfsr[61:0]);
      m_lfsr = step(m_lfsr);
   endtask

   task automatic drain(input string n);
      out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++)
         tick();
      tick();
      chk({n, "_empty_q"}, 64'(exp_q.size()), 64'd0);
      chk({n, "_valid"}, 64'(out_valid), 64'd0);
      out_ready = 1'b0;
   endtask

   // Scoreboard monitor: compare every popped head entry
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL pop_unexpected: got %h want none",
                     out_data);
         end else begin
            if (out_data !== exp_q[0]) begin
               bad++;
               $display("FAIL pop_data: got %h want %h",
                        out_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      m_lfsr = 64'h1;
      #12;
      chk("rst_valid", 64'(out_valid), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_tmo", 64'(timeout), 0);
      chk("rst_tries", 64'(tries_cnt), 0);
      chk("rst_acc", 64'(accept_cnt), 0);
      chk("rst_c0", 64'(cand_var_0), 64'h1);
      chk("rst_c3", 64'(cand_var_3), 64'h0);
      rst_n = 1'b1;
      tick();

      // three consecutive accepts
      target = 16'd3;
      chk_drv = 1'b1;
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t1_busy", 64'(busy), 1);
      chk("t1_c0", 64'(cand_var_0), 64'(m_lfsr[12:0]));
      exp_push();
      exp_push();
      exp_push();
      tick();
      tick();
      chk("t1_done_early", 64'(done), 0);
      tick();
      chk("t1_done", 64'(done), 1);
      chk("t1_acc", 64'(accept_cnt), 3);
      chk("t1_tries", 64'(tries_cnt), 3);
      chk("t1_tmo", 64'(timeout), 0);
      chk("t1_busy_off", 64'(busy), 0);
      drain("t1");

      // reject budget timeout
      chk_drv = 1'b0;
      target = 16'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < MT - 1; i++) begin
         tick();
         if (out_valid) saw = 1'b1;
      end
      chk("t2_done_early", 64'(done), 0);
      chk("t2_tries15", 64'(tries_cnt), MT - 1);
      tick();
      if (out_valid) saw = 1'b1;
      chk("t2_done", 64'(done), 1);
      chk("t2_tmo", 64'(timeout), 1);
      chk("t2_tries", 64'(tries_cnt), MT);
      chk("t2_acc", 64'(accept_cnt), 0);
      chk("t2_novalid", 64'(saw), 0);
      for (int i = 0; i < MT; i++)
         m_lfsr = step(m_lfsr);

      // full FIFO stall and pop-plus-push
      out_ready = 1'b0;
      chk_drv = 1'b1;
      target = 16'd8;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_push();
         tick();
      end
      tick();
      chk("t3_busy", 64'(busy), 1);
      chk("t3_acc4", 64'(accept_cnt), 4);
      chk("t3_tries5", 64'(tries_cnt), 5);
      chk("t3_c0", 64'(cand_var_0), 64'(m_lfsr[12:0]));
      tick();
      chk("t3_c1_hold", 64'(cand_var_1), 64'(m_lfsr[25:13]));
      chk("t3_tries_hold", 64'(tries_cnt), 5);
      chk("t3_acc_hold", 64'(accept_cnt), 4);
      out_ready = 1'b1;
      exp_push();
      tick();
      out_ready = 1'b0;
      chk("t3_acc5", 64'(accept_cnt), 5);
      chk("t3_tries_push", 64'(tries_cnt), 5);
      chk("t3_c0_next", 64'(cand_var_0), 64'(m_lfsr[12:0]));
      tick();
      tick();
      chk("t3_still_full", 64'(accept_cnt), 5);
      chk("t3_c2_hold", 64'(cand_var_2), 64'(m_lfsr[39:26]));
      chk("t3_busy2", 64'(busy), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t3_ab_done", 64'(done), 1);
      chk("t3_ab_acc", 64'(accept_cnt), 5);
      chk("t3_ab_tmo", 64'(timeout), 0);
      drain("t3");

      // abort with a pending accept
      out_ready = 1'b1;
      chk_drv = 1'b1;
      target = 16'd8;
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_push();
      exp_push();
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t4_done", 64'(done), 1);
      chk("t4_busy", 64'(busy), 0);
      chk("t4_tmo", 64'(timeout), 0);
      chk("t4_acc", 64'(accept_cnt), 2);
      chk("t4_tries", 64'(tries_cnt), 2);
      drain("t4");

      // asynchronous reset during a full stall
      out_ready = 1'b0;
      chk_drv = 1'b1;
      target = 16'd8;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++)
         tick();
      chk("t6_pre_busy", 64'(busy), 1);
      chk("t6_pre_valid", 64'(out_valid), 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_valid", 64'(out_valid), 0);
      chk("t6_busy", 64'(busy), 0);
      chk("t6_done", 64'(done), 0);
      chk("t6_tries", 64'(tries_cnt), 0);
      chk("t6_acc", 64'(accept_cnt), 0);
      chk("t6_c0", 64'(cand_var_0), 64'h1);
      chk("t6_c4", 64'(cand_var_4), 64'h0);
      #1;
      rst_n = 1'b1;
      m_lfsr = 64'h1;
      tick();

      // zero target finishes at once
      chk_drv = 1'b1;
      target = 16'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t5_done", 64'(done), 1);
      chk("t5_busy", 64'(busy), 0);
      chk("t5_tries", 64'(tries_cnt), 0);
      tick();
      chk("t5_c0_hold", 64'(cand_var_0), 64'(m_lfsr[12:0]));
      chk("t5_valid", 64'(out_valid), 0);

`ifdef SAMPLE_DEDUP_EN
      // only repeats of the last sample look acceptable
      dd_mode = 1'b1;
      dd_last = '1;
      target = 16'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < MT; i++) begin
         tick();
         if (out_valid) saw = 1'b1;
      end
      chk("dd_done", 64'(done), 1);
      chk("dd_tmo", 64'(timeout), 1);
      chk("dd_acc", 64'(accept_cnt), 0);
      chk("dd_novalid", 64'(saw), 0);
      dd_mode = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
